ysyx_220066_mdu_ctrl: RTL

YSYX_220066_MDU_CTRL -- requirements
Module: ysyx_220066_MDU_ctrl

---
 rtl/ysyx_220066_mdu_pkg.sv | 23 ++
 rtl/ysyx_220066_mdu_step.sv | 35 +++
 rtl/ysyx_220066_mdu_ctrl.sv | 179 +++++++++++++++++
 3 files changed

// File: rtl/ysyx_220066_mdu_pkg.sv
// Shared definitions for the iterative multiply/divide unit:
// FSM state encoding, RV funct3 op codes and default width.
package ysyx_220066_mdu_pkg;

  localparam int XLEN_DEF = 64;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } mdu_state_e;

  localparam logic [2:0] OP_MUL    = 3'b000;
  localparam logic [2:0] OP_MULH   = 3'b001;
  localparam logic [2:0] OP_MULHSU = 3'b010;
  localparam logic [2:0] OP_MULHU  = 3'b011;
  localparam logic [2:0] OP_DIV    = 3'b100;
  localparam logic [2:0] OP_DIVU   = 3'b101;
  localparam logic [2:0] OP_REM    = 3'b110;
  localparam logic [2:0] OP_REMU   = 3'b111;

endpackage

// File: rtl/ysyx_220066_mdu_step.sv
// One iteration on the 2N-bit accumulator: MSB-first shift-add
// for multiply, restoring trial subtract for divide.
module ysyx_220066_mdu_step #(
  parameter int XLEN = 64
) (
  input  logic              is_div,
  input  logic [2*XLEN-1:0] acc,
  input  logic              bit_in,
  input  logic [XLEN-1:0]   opnd,
  output logic [2*XLEN-1:0] acc_nxt
);

  logic [XLEN:0] trial;
  logic [XLEN:0] diff;
  logic          q;

  always_comb begin
    trial   = {acc[2*XLEN-1:XLEN], bit_in};
    diff    = trial - {1'b0, opnd};
    // remainder stays below divisor, so diff's top bit is the borrow
    q       = ~diff[XLEN];
    acc_nxt = '0;
    unique case (1'b1)
      is_div: begin
        acc_nxt = {q ? diff[XLEN-1:0] : trial[XLEN-1:0],
                   acc[XLEN-2:0], q};
      end
      !is_div: begin
        acc_nxt = {acc[2*XLEN-2:0], 1'b0}
                + {{XLEN{1'b0}}, bit_in ? opnd : '0};
      end
    endcase
  end

endmodule

// File: rtl/ysyx_220066_mdu_ctrl.sv
// Multi-cycle RV64M multiply/divide controller: magnitude setup,
// N-cycle iteration, one-cycle sign fix, valid/ready handoff.
module ysyx_220066_mdu_ctrl
  import ysyx_220066_mdu_pkg::*;
#(
  parameter int XLEN = XLEN_DEF
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [2:0]      op,
  input  logic            is_w,
  input  logic [XLEN-1:0] src1,
  input  logic [XLEN-1:0] src2,
  input  logic            flush,
  output logic            busy,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] result
);

  localparam int CW = $clog2(XLEN);
  localparam int W2 = 2 * XLEN;

  function automatic logic [XLEN-1:0] sext_w(
    input logic [XLEN-1:0] v,
    input logic            w
  );
    sext_w = w ? {{(XLEN-32){v[31]}}, v[31:0]} : v;
  endfunction

  mdu_state_e      state;
  logic [CW-1:0]   cnt;
  logic [XLEN-1:0] res_q;
  logic [XLEN-1:0] a_q;
  logic [XLEN-1:0] b_q;
  logic [W2-1:0]   acc;
  logic [2:0]      op_q;
  logic            w_q;
  logic            neg_res;
  logic            neg_rem;

  logic [XLEN-1:0] nmask;
  logic [XLEN-1:0] min_n;
  logic [XLEN-1:0] x1;
  logic [XLEN-1:0] x2;
  logic [XLEN-1:0] m1;
  logic [XLEN-1:0] m2;
  logic [XLEN-1:0] byp;
  logic            s1;
  logic            s2;
  logic            sg1;
  logic            sg2;
  logic            dz;
  logic            ovf;
  logic            accept;

  assign in_ready  = (state == IDLE);
  assign busy      = (state == CALC) || (state == FIX);
  assign out_valid = (state == DONE);
  assign result    = res_q;
  assign accept    = in_ready && in_valid && !flush;

  always_comb begin
    nmask = is_w ? XLEN'(32'hFFFF_FFFF) : '1;
    min_n = is_w ? XLEN'(32'h8000_0000)
                 : {1'b1, {(XLEN-1){1'b0}}};
    x1    = src1 & nmask;
    x2    = src2 & nmask;
    s1    = is_w ? src1[31] : src1[XLEN-1];
    s2    = is_w ? src2[31] : src2[XLEN-1];
    sg1   = s1 && (op == OP_MULH || op == OP_MULHSU ||
                   op == OP_DIV  || op == OP_REM);
    sg2   = s2 && (op == OP_MULH || op == OP_DIV ||
                   op == OP_REM);
    m1    = sg1 ? ((-x1) & nmask) : x1;
    m2    = sg2 ? ((-x2) & nmask) : x2;
    dz    = op[2] && (x2 == '0);
    ovf   = op[2] && !op[0] && (x1 == min_n) && (x2 == nmask);
    // early-out results: quotient in op[1]==0, remainder otherwise
    if (dz)
      byp = op[1] ? x1 : nmask;
    else
      byp = op[1] ? '0 : x1;
  end

  logic [XLEN-1:0] iter;
  logic [XLEN-1:0] opnd;
  logic [W2-1:0]   acc_nxt;

  assign iter = op_q[2] ? a_q : b_q;
  assign opnd = op_q[2] ? b_q : a_q;

  ysyx_220066_mdu_step #(
    .XLEN (XLEN)
  ) u_step (
    .is_div  (op_q[2]),
    .acc     (acc),
    .bit_in  (iter[cnt]),
    .opnd    (opnd),
    .acc_nxt (acc_nxt)
  );

  logic [W2-1:0]   prod;
  logic [XLEN-1:0] quo;
  logic [XLEN-1:0] rem;
  logic [XLEN-1:0] fix_val;
  logic [XLEN-1:0] fix_res;

  always_comb begin
    prod = neg_res ? (-acc) : acc;
    quo  = neg_res ? (-acc[XLEN-1:0]) : acc[XLEN-1:0];
    rem  = neg_rem ? (-acc[W2-1:XLEN]) : acc[W2-1:XLEN];
    unique case (1'b1)
      op_q[2]:
        fix_val = op_q[1] ? rem : quo;
      !op_q[2] && (op_q == OP_MUL):
        fix_val = prod[XLEN-1:0];
      default:
        fix_val = w_q ? XLEN'(prod[63:32]) : prod[W2-1:XLEN];
    endcase
    fix_res = sext_w(fix_val, w_q);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      cnt   <= '0;
      res_q <= '0;
    end else if (flush) begin
      state <= IDLE;
    end else begin
      unique case (state)
        IDLE: begin
          if (in_valid) begin
            if (dz || ovf) begin
              state <= DONE;
              res_q <= sext_w(byp, is_w);
            end else begin
              state <= CALC;
              cnt   <= is_w ? CW'(31) : CW'(XLEN-1);
            end
          end
        end
        CALC: begin
          if (cnt == '0)
            state <= FIX;
          else
            cnt <= cnt - 1'b1;
        end
        FIX: begin
          state <= DONE;
          res_q <= fix_res;
        end
        DONE: begin
          if (out_ready)
            state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      a_q     <= m1;
      b_q     <= m2;
      op_q    <= op;
      w_q     <= is_w;
      neg_res <= sg1 ^ sg2;
      neg_rem <= sg1;
      acc     <= '0;
    end else if (state == CALC) begin
      acc <= acc_nxt;
    end
  end

endmodule
